// File: rtl/sprite_comp_pkg.sv
// Shared types and helpers for the sprite compositor: coordinate width,
// pipeline latency, packed RGB type, transparency test and priority pick.
package sprite_comp_pkg;

    localparam int COORD_W  = 10;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic is_transparent(input logic [31:0] idx, input int unsigned tmax);
        return idx <= tmax;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int lowest_set(input logic [31:0] mask);
        int r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_lane.sv
// One sprite lane: hit test against the current pixel and the registered
// sprite ROM address (row*SPR_W + col), held while the lane is not hit.
module sprite_lane
    import sprite_comp_pkg::*;
#(
    parameter int SPR_W  = 40,
    parameter int SPR_H  = 64,
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_in_active,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_spr_x,
    input  logic [COORD_W-1:0] i_spr_y,
    output logic               o_hit,
    output logic [ADDR_W-1:0]  o_rom_addr
);

    localparam logic [COORD_W-1:0] W_C = COORD_W'(SPR_W);
    localparam logic [COORD_W-1:0] H_C = COORD_W'(SPR_H);

    logic [COORD_W-1:0] w_col;
    logic [COORD_W-1:0] w_row;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  r_addr;

    // Unsigned wrap is intended: a sprite past the right edge reappears at column 0.
    assign w_col  = i_x - i_spr_x;
    assign w_row  = i_y - i_spr_y;
    assign o_hit  = i_en & (w_col < W_C) & (w_row < H_C) & i_in_active;
    assign w_addr = ADDR_W'(w_row) * ADDR_W'(SPR_W) + ADDR_W'(w_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (o_hit) begin
            r_addr <= w_addr;
        end
    end

    assign o_rom_addr = r_addr;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: N_SPR prioritised sprite lanes over a background colour,
// palette lookup to RGB, sticky per-frame collision flags. Define COLL_PAIR_EN
// to add pairwise collision outputs (coll_pair, coll_pair_frame).
module sprite_compositor
    import sprite_comp_pkg::*;
#(
    parameter int N_SPR      = 4,
    parameter int SPR_W      = 40,
    parameter int SPR_H      = 64,
    parameter int IDX_W      = 8,
    parameter int COLOR_W    = 24,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int TRANSP_MAX = 5,
    parameter int ADDR_W     = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     pix_valid,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic [COORD_W-1:0]       DrawY,
    input  logic [COLOR_W-1:0]       bg_color,
    input  logic                     frame_start,
    input  logic [N_SPR-1:0]         spr_en,
    input  logic [N_SPR*COORD_W-1:0] spr_x,
    input  logic [N_SPR*COORD_W-1:0] spr_y,
    output logic [N_SPR*ADDR_W-1:0]  spr_rom_addr,
    input  logic [N_SPR*IDX_W-1:0]   spr_rom_idx,
    input  logic                     pal_we,
    input  logic [IDX_W-1:0]         pal_waddr,
    input  logic [COLOR_W-1:0]       pal_wdata,
    output logic [7:0]               Red,
    output logic [7:0]               Green,
    output logic [7:0]               Blue,
    output logic                     out_valid,
    output logic [N_SPR-1:0]         coll_live,
    output logic [N_SPR-1:0]         coll_frame
`ifdef COLL_PAIR_EN
    ,
    output logic [N_SPR*N_SPR-1:0]   coll_pair,
    output logic [N_SPR*N_SPR-1:0]   coll_pair_frame
`endif
);

    localparam logic [COORD_W-1:0] H_ACT_C = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C = COORD_W'(V_ACTIVE);

    // Reset asserts asynchronously and releases two edges after reset_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic             w_in_active;
    logic [N_SPR-1:0] w_hit;

    assign w_in_active = (DrawX < H_ACT_C) & (DrawY < V_ACT_C);

    for (genvar i = 0; i < N_SPR; i++) begin : g_lane
        sprite_lane #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_lane (
            .clk         (clk),
            .rst_n       (w_rst_n),
            .i_en        (spr_en[i]),
            .i_in_active (w_in_active),
            .i_x         (DrawX),
            .i_y         (DrawY),
            .i_spr_x     (spr_x[i*COORD_W +: COORD_W]),
            .i_spr_y     (spr_y[i*COORD_W +: COORD_W]),
            .o_hit       (w_hit[i]),
            .o_rom_addr  (spr_rom_addr[i*ADDR_W +: ADDR_W])
        );
    end

    // r_vld[0]=S1, [1]=ROM wait, [2]=S2, [PIPE_LAT]=output slot.
    logic [PIPE_LAT:0]  r_vld;
    logic [N_SPR-1:0]   r_s1_hit, r_s1b_hit;
    logic [COLOR_W-1:0] r_s1_bg, r_s1b_bg, r_s2_bg;
    logic               r_s1_act, r_s1b_act, r_s2_act, r_s2_any;
    logic [IDX_W-1:0]   r_s2_idx;
    logic [N_SPR-1:0]   r_coll_live, r_coll_frame;
    logic [COLOR_W-1:0] r_pal [2**IDX_W];
    rgb_t               r_rgb;

    logic [N_SPR-1:0]   w_opaque, w_coll;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_any;

    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < N_SPR; i++) begin
            w_opaque[i] = r_s1b_hit[i] & r_vld[1] &
                          !is_transparent(32'(spr_rom_idx[i*IDX_W +: IDX_W]), TRANSP_MAX);
        end
        w_any     = |w_opaque;
        w_win_idx = spr_rom_idx[lowest_set(32'(w_opaque))*IDX_W +: IDX_W];
        w_coll    = ((w_opaque & (w_opaque - N_SPR'(1))) != '0) ? w_opaque : '0;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vld        <= '0;
            r_s1_hit     <= '0;
            r_s1_bg      <= '0;
            r_s1_act     <= 1'b0;
            r_s1b_hit    <= '0;
            r_s1b_bg     <= '0;
            r_s1b_act    <= 1'b0;
            r_s2_any     <= 1'b0;
            r_s2_idx     <= '0;
            r_s2_bg      <= '0;
            r_s2_act     <= 1'b0;
            r_coll_live  <= '0;
            r_coll_frame <= '0;
        end else begin
            r_vld     <= {r_vld[PIPE_LAT-1:0], pix_valid};
            r_s1_hit  <= w_hit;
            r_s1_bg   <= bg_color;
            r_s1_act  <= w_in_active;
            r_s1b_hit <= r_s1_hit;
            r_s1b_bg  <= r_s1_bg;
            r_s1b_act <= r_s1_act;
            r_s2_any  <= w_any;
            r_s2_idx  <= w_win_idx;
            r_s2_bg   <= r_s1b_bg;
            r_s2_act  <= r_s1b_act;
            // Collisions resolved at the frame_start edge still belong to the closing frame.
            if (frame_start) begin
                r_coll_frame <= r_coll_live | w_coll;
                r_coll_live  <= '0;
            end else begin
                r_coll_live  <= r_coll_live | w_coll;
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int k = 0; k < 2**IDX_W; k++) r_pal[k] <= '0;
        end else if (pal_we) begin
            r_pal[pal_waddr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rgb <= '0;
        end else if (r_vld[2] && r_s2_act) begin
            r_rgb <= rgb_t'(r_s2_any ? r_pal[r_s2_idx][23:0] : r_s2_bg[23:0]);
        end else begin
            r_rgb <= '0;
        end
    end

    assign Red        = r_rgb.r;
    assign Green      = r_rgb.g;
    assign Blue       = r_rgb.b;
    assign out_valid  = r_vld[PIPE_LAT];
    assign coll_live  = r_coll_live;
    assign coll_frame = r_coll_frame;

`ifdef COLL_PAIR_EN
    logic [N_SPR*N_SPR-1:0] w_pair, r_pair_live, r_pair_frame;

    always_comb begin
        w_pair = '0;
        for (int i = 0; i < N_SPR; i++) begin
            for (int j = 0; j < N_SPR; j++) begin
                if (i != j) w_pair[i*N_SPR+j] = w_opaque[i] & w_opaque[j];
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pair_live  <= '0;
            r_pair_frame <= '0;
        end else if (frame_start) begin
            r_pair_frame <= r_pair_live | w_pair;
            r_pair_live  <= '0;
        end else begin
            r_pair_live  <= r_pair_live | w_pair;
        end
    end

    assign coll_pair       = r_pair_live;
    assign coll_pair_frame = r_pair_frame;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: vector table for single pixels plus
// hand-written sequences for bubbles, frame boundaries, palette hazard, reset.
module tb_sprite_compositor;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        pix_valid   = 1'b0;
    logic [9:0]  DrawX       = '0;
    logic [9:0]  DrawY       = '0;
    logic [23:0] bg_color    = '0;
    logic        frame_start = 1'b0;
    logic [3:0]  spr_en      = '0;
    logic [39:0] spr_x       = '0;
    logic [39:0] spr_y       = '0;
    logic [47:0] spr_rom_addr;
    logic [31:0] spr_rom_idx = '0;
    logic        pal_we      = 1'b0;
    logic [7:0]  pal_waddr   = '0;
    logic [23:0] pal_wdata   = '0;
    logic [7:0]  Red, Green, Blue;
    logic        out_valid;
    logic [3:0]  coll_live, coll_frame;
`ifdef COLL_PAIR_EN
    logic [15:0] coll_pair, coll_pair_frame;
`endif

    logic [31:0] rom_cfg = '0;
    int          checks   = 0;
    int          failures = 0;
    logic [24:0] exp_q[$];

    sprite_compositor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pix_valid    (pix_valid),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .bg_color     (bg_color),
        .frame_start  (frame_start),
        .spr_en       (spr_en),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_rom_addr (spr_rom_addr),
        .spr_rom_idx  (spr_rom_idx),
        .pal_we       (pal_we),
        .pal_waddr    (pal_waddr),
        .pal_wdata    (pal_wdata),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .out_valid    (out_valid),
        .coll_live    (coll_live),
        .coll_frame   (coll_frame)
`ifdef COLL_PAIR_EN
        ,
        .coll_pair       (coll_pair),
        .coll_pair_frame (coll_pair_frame)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: one-cycle latency, per-lane constant index.
    always @(posedge clk) spr_rom_idx <= rom_cfg;

    typedef struct packed {
        logic [3:0]  en;
        logic [39:0] sx;
        logic [39:0] sy;
        logic [31:0] rom;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] bg;
        logic [23:0] exp_rgb;
        logic [3:0]  exp_coll;
        logic [11:0] exp_addr0;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pal_write(input logic [7:0] a, input logic [23:0] d);
        @(negedge clk);
        pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    task automatic set_scene(input logic [3:0] en, input logic [39:0] sx, input logic [39:0] sy,
                             input logic [31:0] rom, input logic [9:0] x, input logic [9:0] y,
                             input logic [23:0] bg);
        spr_en = en; spr_x = sx; spr_y = sy; rom_cfg = rom;
        DrawX = x; DrawY = y; bg_color = bg;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        @(negedge clk);
        set_scene(v.en, v.sx, v.sy, v.rom, v.x, v.y, v.bg);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d_early_valid", n), out_valid, 0);
        @(negedge clk);
        chk($sformatf("v%0d_valid", n), out_valid, 1);
        chk($sformatf("v%0d_rgb", n), {Red, Green, Blue}, v.exp_rgb);
        chk($sformatf("v%0d_coll_live", n), coll_live, v.exp_coll);
        chk($sformatf("v%0d_addr0", n), spr_rom_addr[11:0], v.exp_addr0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk($sformatf("v%0d_coll_frame", n), coll_frame, v.exp_coll);
        chk($sformatf("v%0d_live_cleared", n), coll_live, 0);
    endtask

    initial begin
        vec_t pv;
        logic [9:0]  pat;
        logic [24:0] e;
        int lat;

        // Lane 0 at (100,50) unless noted; lanes packed {3,2,1,0}.
        vecs[0] = '{4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd6}, 10'd120, 10'd60, 24'h00A000, 24'hFF0000, 4'b0000, 12'd420};
        vecs[1] = '{4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd3}, 10'd120, 10'd60, 24'h00A000, 24'h00A000, 4'b0000, 12'd420};
        vecs[2] = '{4'b0101, {10'd0,10'd200,10'd0,10'd200}, {10'd0,10'd100,10'd0,10'd100},
                    {8'd0,8'd9,8'd0,8'd7}, 10'd200, 10'd100, 24'h000000, 24'h112233, 4'b0101, 12'd0};
        vecs[3] = '{4'b0011, {10'd0,10'd0,10'd630,10'd630}, {10'd0,10'd0,10'd0,10'd0},
                    {8'd0,8'd0,8'd9,8'd7}, 10'd640, 10'd10, 24'h00A000, 24'h000000, 4'b0000, 12'd0};
        vecs[4] = '{4'b0001, {10'd0,10'd0,10'd0,10'd1000}, {10'd0,10'd0,10'd0,10'd0},
                    {8'd0,8'd0,8'd0,8'd8}, 10'd5, 10'd0, 24'h00A000, 24'h0000FF, 4'b0000, 12'd29};
        vecs[5] = '{4'b1011, {10'd300,10'd300,10'd300,10'd300}, {10'd200,10'd200,10'd200,10'd200},
                    {8'd9,8'd7,8'd8,8'd5}, 10'd305, 10'd210, 24'h00A000, 24'h0000FF, 4'b1010, 12'd405};
        vecs[6] = '{4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd6}, 10'd140, 10'd60, 24'h123456, 24'h123456, 4'b0000, 12'd405};
        vecs[7] = '{4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd6}, 10'd139, 10'd113, 24'h123456, 24'hFF0000, 4'b0000, 12'd2559};
        vecs[8] = '{4'b0000, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd6}, 10'd120, 10'd60, 24'h654321, 24'h654321, 4'b0000, 12'd2559};
        vecs[9] = '{4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                    {8'd0,8'd0,8'd0,8'd6}, 10'd120, 10'd114, 24'h0F0F0F, 24'h0F0F0F, 4'b0000, 12'd2559};

        // Reset and post-reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rgb", {Red, Green, Blue}, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_coll_live", coll_live, 0);
        chk("reset_coll_frame", coll_frame, 0);
        chk("reset_rom_addr", spr_rom_addr, 0);

        // Palette is cleared by reset: an opaque hit yields black, not bg.
        pv = vecs[0];
        pv.exp_rgb = 24'h000000;
        run_vec(100, pv);

        pal_write(8'd6, 24'hFF0000);
        pal_write(8'd7, 24'h112233);
        pal_write(8'd8, 24'h0000FF);
        pal_write(8'd9, 24'h445566);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Bubbles: out_valid mirrors the pix_valid pattern four negedges later.
        @(negedge clk);
        set_scene(4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                  {8'd0,8'd0,8'd0,8'd6}, 10'd120, 10'd60, 24'h00A000);
        pat = 10'b0000110011;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                e = exp_q.pop_front();
                chk("bubble_valid", out_valid, e[24]);
                chk("bubble_rgb", {Red, Green, Blue}, e[23:0]);
            end
            pix_valid = (k < 10) ? pat[k] : 1'b0;
            exp_q.push_back({pix_valid, pix_valid ? 24'hFF0000 : 24'h000000});
        end

        // Invalid slots over an overlap never set collision bits.
        @(negedge clk);
        set_scene(4'b0101, {10'd0,10'd200,10'd0,10'd200}, {10'd0,10'd100,10'd0,10'd100},
                  {8'd0,8'd9,8'd0,8'd7}, 10'd200, 10'd100, 24'h000000);
        repeat (7) @(negedge clk);
        chk("bubble_no_coll", coll_live, 0);

        // frame_start coinciding with a colliding pixel's resolve edge.
        pix_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_edge_frame", coll_frame, 4'b0101);
        chk("fs_edge_live", coll_live, 0);
        @(negedge clk);
        chk("fs_next_live", coll_live, 4'b0101);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_second_frame", coll_frame, 4'b0101);

        // Palette write in the same cycle as an S3 read of that entry.
        set_scene(4'b0001, {10'd0,10'd0,10'd0,10'd100}, {10'd0,10'd0,10'd0,10'd50},
                  {8'd0,8'd0,8'd0,8'd7}, 10'd120, 10'd60, 24'h00A000);
        @(negedge clk);
        pix_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
        @(negedge clk);
        pal_we = 1'b1; pal_waddr = 8'd7; pal_wdata = 24'hAABBCC;
        @(negedge clk);
        pal_we = 1'b0;
        chk("pal_hazard_old", {Red, Green, Blue}, 24'h112233);
        @(negedge clk);
        chk("pal_hazard_new", {Red, Green, Blue}, 24'hAABBCC);

        // Reset asserted mid-stream with live collisions.
        set_scene(4'b0101, {10'd0,10'd100,10'd0,10'd100}, {10'd0,10'd50,10'd0,10'd50},
                  {8'd0,8'd9,8'd0,8'd6}, 10'd120, 10'd60, 24'h00A000);
        pix_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_rgb", {Red, Green, Blue}, 24'hFF0000);
        chk("pre_reset_live", coll_live, 4'b0101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_rgb", {Red, Green, Blue}, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_coll_live", coll_live, 0);
        chk("midrst_coll_frame", coll_frame, 0);
        chk("midrst_rom_addr", spr_rom_addr, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("rst_first_valid", out_valid, 1);
        chk("rst_latency_min", (lat >= 4), 1);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
